// File: rtl/mult_err_pkg.sv
// rtl/mult_err_pkg.sv - shared types and widths for the multiplier error monitor
//
// Purpose : FSM state encoding and operand/product widths used by
//           mult_err_ed_stage and mult_8x8_err_monitor.
// Ports   : none (package).
// Config  : ERR_MON_BIAS_EN does not affect this file.

package mult_err_pkg;

  localparam int OP_W   = 8;
  localparam int PROD_W = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    REPORT = 2'd2
  } err_mon_state_e;

endpackage

// File: rtl/mult_err_ed_stage.sv
// rtl/mult_err_ed_stage.sv - two-stage exact-product and error-distance pipeline
//
// Purpose : S1 registers the operand pair and the approximate product.
//           S2 registers ed = |a*b - r| and nz = (ed != 0).
// Ports   : clk, rst_n         clock, asynchronous active-low reset
//           flush              clears both stage valid bits
//           valid, a, b, r     incoming sample
//           ed, nz, ed_valid   S2 result and its qualifier
//           err                (ERR_MON_BIAS_EN only) signed a*b - r
// Config  : ERR_MON_BIAS_EN adds the signed error output.

module mult_err_ed_stage
  import mult_err_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              valid,
  input  logic [OP_W-1:0]   a,
  input  logic [OP_W-1:0]   b,
  input  logic [PROD_W-1:0] r,
  output logic [PROD_W-1:0] ed,
  output logic              nz,
  output logic              ed_valid
`ifdef ERR_MON_BIAS_EN
  , output logic signed [PROD_W:0] err
`endif
);

  logic [OP_W-1:0]   s1_a;
  logic [OP_W-1:0]   s1_b;
  logic [PROD_W-1:0] s1_r;
  logic              s1_valid;
  logic [PROD_W-1:0] exact;
  logic [PROD_W-1:0] ed_d;

  // An 8x8 product always fits in 16 bits, so no carry is lost here.
  assign exact = {{(PROD_W-OP_W){1'b0}}, s1_a} * {{(PROD_W-OP_W){1'b0}}, s1_b};
  assign ed_d  = (exact >= s1_r) ? (exact - s1_r) : (s1_r - exact);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_a     <= '0;
      s1_b     <= '0;
      s1_r     <= '0;
      s1_valid <= 1'b0;
      ed       <= '0;
      nz       <= 1'b0;
      ed_valid <= 1'b0;
`ifdef ERR_MON_BIAS_EN
      err      <= '0;
`endif
    end else begin
      s1_a     <= a;
      s1_b     <= b;
      s1_r     <= r;
      ed       <= ed_d;
      nz       <= (ed_d != '0);
`ifdef ERR_MON_BIAS_EN
      err      <= $signed({1'b0, exact}) - $signed({1'b0, s1_r});
`endif
      // Only the qualifiers need flushing; stale data behind a cleared
      // valid is never consumed.
      s1_valid <= valid & ~flush;
      ed_valid <= s1_valid & ~flush;
    end
  end

endmodule

// File: rtl/mult_8x8_err_monitor.sv
// rtl/mult_8x8_err_monitor.sv - windowed error statistics for 8x8 approximate multipliers
//
// Purpose : Over a window of 2^WIN_LOG2 samples, counts samples whose product
//           is wrong, sums the error distance and tracks its maximum, then
//           reports the totals with a one-cycle rpt_valid pulse.
// Ports   : clk, rst_n                   clock, asynchronous active-low reset
//           start                        clear accumulators and open a window
//           in_valid, in_a, in_b, in_r   operand pair and approximate product
//           busy                         window open or report in progress
//           rpt_valid                    results below have just been updated
//           err_cnt, sum_ed, max_ed      window results, held until next report
//           sum_err                      (ERR_MON_BIAS_EN only) signed error sum
// Config  : define ERR_MON_BIAS_EN to add the signed bias accumulator.

module mult_8x8_err_monitor
  import mult_err_pkg::*;
#(
  parameter  int WIN_LOG2 = 16,
  localparam int CNT_W    = WIN_LOG2 + 1,
  localparam int SUM_W    = 16 + WIN_LOG2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [OP_W-1:0]   in_a,
  input  logic [OP_W-1:0]   in_b,
  input  logic [PROD_W-1:0] in_r,
  output logic              busy,
  output logic              rpt_valid,
  output logic [CNT_W-1:0]  err_cnt,
  output logic [SUM_W-1:0]  sum_ed,
  output logic [PROD_W-1:0] max_ed
`ifdef ERR_MON_BIAS_EN
  , output logic signed [SUM_W:0] sum_err
`endif
);

  localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'((1 << WIN_LOG2) - 1);

  err_mon_state_e    state_q;
  err_mon_state_e    state_d;
  logic              flush;
  logic              acc_en;
  logic              win_done;
  logic [PROD_W-1:0] s2_ed;
  logic              s2_nz;
  logic              s2_valid;
  logic [CNT_W-1:0]  sample_cnt;
  logic [CNT_W-1:0]  acc_err;
  logic [SUM_W-1:0]  acc_sum;
  logic [PROD_W-1:0] acc_max;
`ifdef ERR_MON_BIAS_EN
  logic signed [PROD_W:0] s2_err;
  logic signed [SUM_W:0]  acc_bias;
`endif

  // start is ignored during the single REPORT cycle so a report can never be
  // torn between old and cleared accumulators.
  assign flush    = start && (state_q != REPORT);
  // A restart takes priority over the sample arriving in the same cycle.
  assign acc_en   = (state_q == ACCUM) && s2_valid && !start;
  assign win_done = acc_en && (sample_cnt == WIN_LAST);
  assign busy     = (state_q != IDLE);

  mult_err_ed_stage u_ed_stage (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .valid    (in_valid),
    .a        (in_a),
    .b        (in_b),
    .r        (in_r),
    .ed       (s2_ed),
    .nz       (s2_nz),
    .ed_valid (s2_valid)
`ifdef ERR_MON_BIAS_EN
    , .err    (s2_err)
`endif
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = ACCUM;
      ACCUM:   if (start) state_d = ACCUM;
               else if (win_done) state_d = REPORT;
      REPORT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_cnt <= '0;
      acc_err    <= '0;
      acc_sum    <= '0;
      acc_max    <= '0;
`ifdef ERR_MON_BIAS_EN
      acc_bias   <= '0;
`endif
    end else if (flush) begin
      sample_cnt <= '0;
      acc_err    <= '0;
      acc_sum    <= '0;
      acc_max    <= '0;
`ifdef ERR_MON_BIAS_EN
      acc_bias   <= '0;
`endif
    end else if (acc_en) begin
      sample_cnt <= sample_cnt + CNT_W'(1);
      acc_err    <= acc_err + CNT_W'(s2_nz);
      acc_sum    <= acc_sum + SUM_W'(s2_ed);
      // Strictly greater: a tie leaves the stored maximum untouched.
      if (s2_ed > acc_max) acc_max <= s2_ed;
`ifdef ERR_MON_BIAS_EN
      acc_bias   <= acc_bias + (SUM_W+1)'(s2_err);
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rpt_valid <= 1'b0;
      err_cnt   <= '0;
      sum_ed    <= '0;
      max_ed    <= '0;
`ifdef ERR_MON_BIAS_EN
      sum_err   <= '0;
`endif
    end else begin
      rpt_valid <= (state_q == REPORT);
      if (state_q == REPORT) begin
        err_cnt <= acc_err;
        sum_ed  <= acc_sum;
        max_ed  <= acc_max;
`ifdef ERR_MON_BIAS_EN
        sum_err <= acc_bias;
`endif
      end
    end
  end

endmodule

// File: tb/tb_mult_8x8_err_monitor.sv
// tb/tb_mult_8x8_err_monitor.sv - scoreboard bench for mult_8x8_err_monitor

module tb_mult_8x8_err_monitor;

  localparam int WL  = 2;
  localparam int WIN = 1 << WL;
  localparam int CW  = WL + 1;
  localparam int SW  = 16 + WL;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          in_valid;
  logic [7:0]    in_a;
  logic [7:0]    in_b;
  logic [15:0]   in_r;
  logic          busy;
  logic          rpt_valid;
  logic [CW-1:0] err_cnt;
  logic [SW-1:0] sum_ed;
  logic [15:0]   max_ed;
`ifdef ERR_MON_BIAS_EN
  logic signed [SW:0] sum_err;
`endif

  mult_8x8_err_monitor #(.WIN_LOG2(WL)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .in_valid  (in_valid),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_r      (in_r),
    .busy      (busy),
    .rpt_valid (rpt_valid),
    .err_cnt   (err_cnt),
    .sum_ed    (sum_ed),
    .max_ed    (max_ed)
`ifdef ERR_MON_BIAS_EN
    , .sum_err (sum_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    longint err;
    longint sum;
    longint mx;
    longint bias;
    int     cyc;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference model: the statistics of the first WIN valid samples after the
  // most recent start, using plain integer arithmetic.
  bit     m_open = 1'b0;
  int     m_n;
  longint m_err, m_sum, m_max, m_bias;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // One clock cycle of stimulus, driven 1 ns after the rising edge.
  task automatic drive(input bit s, input bit v, input logic [7:0] a,
                       input logic [7:0] b, input logic [15:0] r);
    longint exact, d;
    exp_t   e;
    @(posedge clk);
    #1;
    start = s; in_valid = v; in_a = a; in_b = b; in_r = r;
    if (s) begin
      m_open = 1'b1; m_n = 0; m_err = 0; m_sum = 0; m_max = 0; m_bias = 0;
    end else if (v && m_open) begin
      exact  = longint'(a) * longint'(b);
      d      = exact - longint'(r);
      m_bias += d;
      if (d < 0) d = -d;
      m_sum += d;
      if (d != 0) m_err++;
      if (d > m_max) m_max = d;
      m_n++;
      if (m_n == WIN) begin
        e.err = m_err; e.sum = m_sum; e.mx = m_max; e.bias = m_bias;
        e.cyc = cyc + 4;
        q.push_back(e);
        m_open = 1'b0;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 8'd0, 8'd0, 16'd0);
  endtask

  // Monitor: pops the oldest expected report each time the DUT reports.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && rpt_valid) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_report actual=1 expected=0 at cycle %0d", cyc);
      end else begin
        e = q.pop_front();
        chk("err_cnt", longint'(err_cnt), e.err);
        chk("sum_ed",  longint'(sum_ed),  e.sum);
        chk("max_ed",  longint'(max_ed),  e.mx);
        chk("rpt_cycle", longint'(cyc), longint'(e.cyc));
        chk("busy_at_report", longint'(busy), 0);
`ifdef ERR_MON_BIAS_EN
        chk("sum_err", longint'(sum_err), e.bias);
`endif
      end
    end
  end

  logic [7:0]  ra, rb;
  logic [15:0] rr, rex;

  initial begin
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0;
    in_a = '0; in_b = '0; in_r = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", longint'(busy), 0);
    chk("reset_rpt_valid", longint'(rpt_valid), 0);
    chk("reset_err_cnt", longint'(err_cnt), 0);
    chk("reset_sum_ed", longint'(sum_ed), 0);
    chk("reset_max_ed", longint'(max_ed), 0);
    rst_n = 1'b1;

    // Exact products.
    drive(1'b1, 1'b0, 8'd0, 8'd0, 16'd0);
    drive(1'b0, 1'b1, 8'd3, 8'd5, 16'd15);
    chk("busy_accum", longint'(busy), 1);
    repeat (3) drive(1'b0, 1'b1, 8'd3, 8'd5, 16'd15);
    idle(6);

    // Mixed errors, including a tie on max_ed is not possible here; ED 3,0,2,15.
    drive(1'b1, 1'b0, 8'd0, 8'd0, 16'd0);
    drive(1'b0, 1'b1, 8'd3, 8'd5, 16'd12);
    drive(1'b0, 1'b1, 8'd3, 8'd5, 16'd15);
    drive(1'b0, 1'b1, 8'd3, 8'd5, 16'd17);
    drive(1'b0, 1'b1, 8'd3, 8'd5, 16'd0);
    idle(6);

    // Results hold across a new start.
    drive(1'b1, 1'b0, 8'd0, 8'd0, 16'd0);
    idle(1);
    chk("hold_err_cnt", longint'(err_cnt), 3);
    chk("hold_sum_ed", longint'(sum_ed), 20);
    chk("hold_max_ed", longint'(max_ed), 15);

    // Worst case ED 65025 every sample; max ties along the way.
    drive(1'b1, 1'b0, 8'd0, 8'd0, 16'd0);
    repeat (4) drive(1'b0, 1'b1, 8'd255, 8'd255, 16'd0);
    idle(6);

    // Asynchronous reset mid-window.
    drive(1'b1, 1'b0, 8'd0, 8'd0, 16'd0);
    repeat (2) drive(1'b0, 1'b1, 8'd7, 8'd9, 16'd1);
    #1;
    rst_n = 1'b0;
    #1;
    m_open = 1'b0;
    chk("rst_busy", longint'(busy), 0);
    chk("rst_rpt_valid", longint'(rpt_valid), 0);
    chk("rst_err_cnt", longint'(err_cnt), 0);
    chk("rst_sum_ed", longint'(sum_ed), 0);
    chk("rst_max_ed", longint'(max_ed), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(8);

    // Six back-to-back samples with ED=1; last two fall outside the window.
    drive(1'b1, 1'b0, 8'd0, 8'd0, 16'd0);
    repeat (6) drive(1'b0, 1'b1, 8'd3, 8'd5, 16'd16);
    idle(6);

    // Restart after two samples; in-flight ones must be flushed.
    drive(1'b1, 1'b0, 8'd0, 8'd0, 16'd0);
    repeat (2) drive(1'b0, 1'b1, 8'd3, 8'd5, 16'd17);
    drive(1'b1, 1'b0, 8'd0, 8'd0, 16'd0);
    repeat (4) drive(1'b0, 1'b1, 8'd3, 8'd5, 16'd13);
    idle(6);

    // Randomized windows with gaps, restarts and varied error patterns.
    for (int w = 0; w < 40; w++) begin
      drive(1'b1, 1'b0, 8'd0, 8'd0, 16'd0);
      while (m_open) begin
        if ($urandom_range(0, 9) == 0) begin
          idle(1);
        end else if ($urandom_range(0, 24) == 0) begin
          drive(1'b1, 1'b0, 8'd0, 8'd0, 16'd0);
        end else begin
          ra  = 8'($urandom);
          rb  = 8'($urandom);
          rex = 16'(32'(ra) * 32'(rb));
          case ($urandom_range(0, 2))
            0:       rr = rex;
            1:       rr = rex ^ 16'($urandom_range(0, 15));
            default: rr = 16'($urandom);
          endcase
          drive(1'b0, 1'b1, ra, rb, rr);
        end
      end
      if ($urandom_range(0, 1) == 1) drive(1'b0, 1'b1, 8'd1, 8'd1, 16'd0);
      idle(6);
    end

    for (int i = 0; i < 50 && q.size() != 0; i++) @(posedge clk);
    if (q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL report_timeout actual=%0d expected=0 pending", q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mult_8x8_err_monitor.md
Name: mult_8x8_err_monitor

Overview:
- Downstream consumer of the 8x8 approximate multipliers (the OR-combined 4x4 partial-product variants).
- Takes each operand pair A/B together with the approximate product R the multiplier produced, and recomputes the exact product internally.
- Over a fixed window of 2^WIN_LOG2 samples, accumulates error count, sum of error distance (ED) and max ED, then reports them with a one-cycle pulse.
- Used for on-silicon/FPGA characterisation of library multipliers (error rate, MED, worst-case error).

Parameters:
- WIN_LOG2, 16: window length is 2^WIN_LOG2 samples; legal range 1..24.
- CNT_W, WIN_LOG2+1: width of the sample counter and err_cnt (derived; do not override).
- SUM_W, 16+WIN_LOG2: width of sum_ed (derived; cannot overflow by construction).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse: flush pipeline, clear accumulators, open a window.
- in_valid  in  1  sample qualifier.
- in_a  in  8  operand A as presented to the multiplier.
- in_b  in  8  operand B.
- in_r  in  16  approximate product R for this A/B.
- busy  out  1  high in ACCUM and REPORT.
- rpt_valid  out  1  one-cycle pulse when results update.
- err_cnt  out  CNT_W  number of samples with ED != 0.
- sum_ed  out  SUM_W  sum of ED over the window.
- max_ed  out  16  largest ED in the window.

Behaviour:
- Reset: all outputs 0; FSM in IDLE; pipeline valids 0; accumulators 0.
- Pipeline (no backpressure; a sample is accepted every cycle that in_valid=1):
  - S1 registers in_a, in_b, in_r, in_valid.
  - S2 registers exact = a*b (16 b), then ed = |exact - r| (16 b unsigned) and nz = (ed != 0).
  - S3 accumulates.
  - A sample presented at cycle t is accumulated at edge t+3.
- FSM states: IDLE, ACCUM, REPORT.
  - IDLE: start -> ACCUM. The same edge clears the S1/S2 valid bits, sample_cnt, acc_err, acc_sum and acc_max. Samples reaching S3 in IDLE are discarded.
  - ACCUM: each S3-valid sample does:
    - sample_cnt += 1
    - acc_err += nz
    - acc_sum += ed
    - acc_max = max(acc_max, ed)
  - ACCUM -> REPORT on the edge that accumulates sample number 2^WIN_LOG2. Later in-flight samples are discarded.
  - start in ACCUM: restarts the window (same clearing as from IDLE) and stays in ACCUM.
  - REPORT (exactly 1 cycle):
    - err_cnt, sum_ed and max_ed are loaded from the accumulators; rpt_valid = 1.
    - Next state is IDLE; start here is ignored.
    - Values are registered, so they become visible in the cycle after REPORT. rpt_valid goes high in that same cycle.
- Result registers hold until the next report; start does not clear them.
- Boundaries:
  - ED = 65025 (exact 255*255, R=0) must accumulate without truncation.
  - max_ed ties keep the value (no change).
  - err_cnt can equal 2^WIN_LOG2; this is why it is CNT_W wide.
- rst_n asserted mid-window: immediate return to the reset state; partial results are lost.

Optional Feature:
- Macro ERR_MON_BIAS_EN.
- When defined:
  - Extra output sum_err, signed, SUM_W+1 bits, equal to the sum of (exact - r) over the window.
  - Cleared and reported with the same timing as sum_ed; reset value 0.
  - Shows the systematic bias of OR-combined variants.
- When undefined: the port and its accumulator are absent; all other behaviour is identical.

Decomposition:
- Package mult_err_pkg holds:
  - State enum err_mon_state_e {IDLE, ACCUM, REPORT}.
  - Localparams OP_W=8 and PROD_W=16.
- One sub-module, mult_err_ed_stage: registered S1/S2. Inputs a/b/r/valid plus flush; outputs ed, nz, valid.
- Top module holds the FSM and the accumulators.

Test Plan (WIN_LOG2=2, window = 4 samples):
- Exact samples: start; 4 samples (3,5,r=15) -> rpt_valid once, 7 cycles after the first sample; err_cnt=0, sum_ed=0, max_ed=0.
- Mixed errors: 4 samples with r=12, 15, 17, 0 for A=3, B=5 -> err_cnt=3, sum_ed=3+0+2+15=20, max_ed=15.
- Worst case: 4 samples (255,255,r=0) -> sum_ed=260100, max_ed=65025, err_cnt=4; no truncation.
- Window closing with extras: 6 back-to-back valid samples, 2 of them after the window closes, all with ED=1 -> sum_ed=4. Extras discarded; busy drops after REPORT.
- Restart: start again mid-window after 2 samples, then 4 new samples with ED=2 -> sum_ed=8. Earlier samples excluded; in-flight samples flushed.
- Reset: rst_n low mid-window -> all outputs 0 asynchronously. With ERR_MON_BIAS_EN defined, the mixed-errors case gives sum_err = +3 + 0 - 2 + 15 = 16.
